// File: rtl/decode_issue_stage_pkg.sv
// rtl/decode_issue_stage_pkg.sv - shared state encoding and control-bundle layout for the decode/issue stage
package decode_issue_stage_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_IMM = 1'b1
  } state_e;

  // Layout of the decoded control bundle carried through to EX (LSB first: alu_op).
  typedef struct packed {
    logic [1:0] rsvd;
    logic       mem_write;
    logic       wb_en;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/decode_issue_stage_load_use_detect.sv
// rtl/decode_issue_stage_load_use_detect.sv - load-use hazard compare between ID/EX and the ID read addresses
module load_use_detect #(
  parameter int N = 3
) (
  input  logic         ex_valid_i,
  input  logic         ex_mem_read_i,
  input  logic [N-1:0] ex_dst_i,
  input  logic [N-1:0] rd_src_i,
  input  logic [N-1:0] rd_dst_i,
  input  logic         uses_src_i,
  input  logic         uses_dst_i,
  output logic         hz_o
);

  assign hz_o = ex_valid_i & ex_mem_read_i &
                ((uses_src_i & (ex_dst_i == rd_src_i)) |
                 (uses_dst_i & (ex_dst_i == rd_dst_i)));

endmodule

// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - register read, load-use stall, two-word immediate assembly and ID/EX register
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int W  = 16,
  parameter int N  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [N-1:0]  id_src,
  input  logic [N-1:0]  id_dst,
  input  logic          id_uses_src,
  input  logic          id_uses_dst,
  input  logic          id_has_imm,
  input  logic          id_mem_read,
  input  logic [CW-1:0] id_ctrl,
  input  logic [W-1:0]  fetch_word,
  input  logic [W-1:0]  rf_rsrc,
  input  logic [W-1:0]  rf_rdst,
  input  logic          ex_flush,
  output logic [N-1:0]  rf_src,
  output logic [N-1:0]  rf_dst,
  output logic          stall_fetch,
  output logic          ex_valid,
  output logic [CW-1:0] ex_ctrl,
  output logic          ex_mem_read,
  output logic [N-1:0]  ex_src,
  output logic [N-1:0]  ex_dst,
  output logic [W-1:0]  ex_rsrc,
  output logic [W-1:0]  ex_rdst,
  output logic [W-1:0]  ex_imm,
  output logic [15:0]   stall_count
);

  state_e        state_q, state_d;
  logic [N-1:0]  h_src_q, h_src_d, h_dst_q, h_dst_d;
  logic          h_uses_src_q, h_uses_src_d, h_uses_dst_q, h_uses_dst_d;
  logic          h_mem_read_q, h_mem_read_d;
  logic [CW-1:0] h_ctrl_q, h_ctrl_d;

  logic          ex_valid_q, ex_valid_d, ex_mem_read_q, ex_mem_read_d;
  logic [CW-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [N-1:0]  ex_src_q, ex_src_d, ex_dst_q, ex_dst_d;
  logic [W-1:0]  ex_rsrc_q, ex_rsrc_d, ex_rdst_q, ex_rdst_d, ex_imm_q, ex_imm_d;
  logic [15:0]   stall_count_q, stall_count_d;

  logic waiting, uses_src, uses_dst, hz, stall_c;

  // While waiting for the immediate word, IF/ID holds that word, so reads come from the held instruction.
  assign waiting  = (state_q == WAIT_IMM);
  assign rf_src   = waiting ? h_src_q      : id_src;
  assign rf_dst   = waiting ? h_dst_q      : id_dst;
  assign uses_src = waiting ? h_uses_src_q : id_uses_src;
  assign uses_dst = waiting ? h_uses_dst_q : id_uses_dst;

  load_use_detect #(.N(N)) u_load_use_detect (
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_mem_read_q),
    .ex_dst_i      (ex_dst_q),
    .rd_src_i      (rf_src),
    .rd_dst_i      (rf_dst),
    .uses_src_i    (uses_src),
    .uses_dst_i    (uses_dst),
    .hz_o          (hz)
  );

  always_comb begin
    state_d       = state_q;
    h_src_d       = h_src_q;
    h_dst_d       = h_dst_q;
    h_uses_src_d  = h_uses_src_q;
    h_uses_dst_d  = h_uses_dst_q;
    h_mem_read_d  = h_mem_read_q;
    h_ctrl_d      = h_ctrl_q;
    ex_valid_d    = 1'b0;
    ex_ctrl_d     = CW'(CTRL_BUBBLE);
    ex_mem_read_d = 1'b0;
    ex_src_d      = '0;
    ex_dst_d      = '0;
    ex_rsrc_d     = '0;
    ex_rdst_d     = '0;
    ex_imm_d      = '0;
    stall_count_d = stall_count_q;
    stall_c       = 1'b0;

    if (ex_flush) begin
      state_d      = IDLE;
      h_src_d      = '0;
      h_dst_d      = '0;
      h_uses_src_d = 1'b0;
      h_uses_dst_d = 1'b0;
      h_mem_read_d = 1'b0;
      h_ctrl_d     = '0;
    end else if (!waiting && !in_valid) begin
      state_d = IDLE;
    end else if (hz) begin
      stall_c = 1'b1;
      if (stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
    end else if (!waiting && id_has_imm) begin
      state_d      = WAIT_IMM;
      h_src_d      = id_src;
      h_dst_d      = id_dst;
      h_uses_src_d = id_uses_src;
      h_uses_dst_d = id_uses_dst;
      h_mem_read_d = id_mem_read;
      h_ctrl_d     = id_ctrl;
    end else if (!waiting || in_valid) begin
      // Issue: a plain instruction from IDLE, or the held one now that its immediate has arrived.
      state_d       = IDLE;
      ex_valid_d    = 1'b1;
      ex_ctrl_d     = waiting ? h_ctrl_q     : id_ctrl;
      ex_mem_read_d = waiting ? h_mem_read_q : id_mem_read;
      ex_src_d      = rf_src;
      ex_dst_d      = rf_dst;
      ex_rsrc_d     = rf_rsrc;
      ex_rdst_d     = rf_rdst;
      ex_imm_d      = waiting ? fetch_word : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      h_src_q       <= '0;
      h_dst_q       <= '0;
      h_uses_src_q  <= 1'b0;
      h_uses_dst_q  <= 1'b0;
      h_mem_read_q  <= 1'b0;
      h_ctrl_q      <= '0;
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_mem_read_q <= 1'b0;
      ex_src_q      <= '0;
      ex_dst_q      <= '0;
      ex_rsrc_q     <= '0;
      ex_rdst_q     <= '0;
      ex_imm_q      <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      h_src_q       <= h_src_d;
      h_dst_q       <= h_dst_d;
      h_uses_src_q  <= h_uses_src_d;
      h_uses_dst_q  <= h_uses_dst_d;
      h_mem_read_q  <= h_mem_read_d;
      h_ctrl_q      <= h_ctrl_d;
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_mem_read_q <= ex_mem_read_d;
      ex_src_q      <= ex_src_d;
      ex_dst_q      <= ex_dst_d;
      ex_rsrc_q     <= ex_rsrc_d;
      ex_rdst_q     <= ex_rdst_d;
      ex_imm_q      <= ex_imm_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_fetch = stall_c & ~rst;
  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_mem_read = ex_mem_read_q;
  assign ex_src      = ex_src_q;
  assign ex_dst      = ex_dst_q;
  assign ex_rsrc     = ex_rsrc_q;
  assign ex_rdst     = ex_rdst_q;
  assign ex_imm      = ex_imm_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - directed bench with a cycle-level reference model of the decode/issue stage
module tb_decode_issue_stage;
  localparam int W = 16, N = 3, CW = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid, id_uses_src, id_uses_dst, id_has_imm, id_mem_read, ex_flush;
  logic [N-1:0] id_src, id_dst, rf_src, rf_dst, ex_src, ex_dst;
  logic [CW-1:0] id_ctrl, ex_ctrl;
  logic [W-1:0] fetch_word, rf_rsrc, rf_rdst, ex_rsrc, ex_rdst, ex_imm;
  logic stall_fetch, ex_valid, ex_mem_read;
  logic [15:0] stall_count;

  logic [W-1:0] rf_mem [2**N];
  assign rf_rsrc = rf_mem[rf_src];
  assign rf_rdst = rf_mem[rf_dst];

  always #5 clk = ~clk;

  decode_issue_stage #(.W(W), .N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .id_src(id_src), .id_dst(id_dst),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst), .id_has_imm(id_has_imm),
    .id_mem_read(id_mem_read), .id_ctrl(id_ctrl), .fetch_word(fetch_word),
    .rf_rsrc(rf_rsrc), .rf_rdst(rf_rdst), .ex_flush(ex_flush), .rf_src(rf_src),
    .rf_dst(rf_dst), .stall_fetch(stall_fetch), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_mem_read(ex_mem_read), .ex_src(ex_src), .ex_dst(ex_dst), .ex_rsrc(ex_rsrc),
    .ex_rdst(ex_rdst), .ex_imm(ex_imm), .stall_count(stall_count)
  );

  int tests = 0, fails = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "is an immediate instruction parked?", the parked instruction, and what ID/EX must hold.
  logic          m_wait;
  logic [N-1:0]  mh_src, mh_dst;
  logic          mh_us, mh_ud, mh_mr;
  logic [CW-1:0] mh_ctrl;
  logic          me_v, me_mr;
  logic [CW-1:0] me_ctrl;
  logic [N-1:0]  me_src, me_dst;
  logic [W-1:0]  me_rsrc, me_rdst, me_imm;
  int            m_cnt;

  function automatic logic [N-1:0] m_src(); return m_wait ? mh_src : id_src; endfunction
  function automatic logic [N-1:0] m_dst(); return m_wait ? mh_dst : id_dst; endfunction
  function automatic logic m_hz();
    logic us, ud;
    us = m_wait ? mh_us : id_uses_src;
    ud = m_wait ? mh_ud : id_uses_dst;
    return me_v && me_mr && ((us && me_dst == m_src()) || (ud && me_dst == m_dst()));
  endfunction
  function automatic logic m_stall();
    return !rst && !ex_flush && (m_wait || in_valid) && m_hz();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 1'b0; mh_src <= '0; mh_dst <= '0; mh_us <= 1'b0; mh_ud <= 1'b0; mh_mr <= 1'b0;
      mh_ctrl <= '0; me_v <= 1'b0; me_mr <= 1'b0; me_ctrl <= '0; me_src <= '0; me_dst <= '0;
      me_rsrc <= '0; me_rdst <= '0; me_imm <= '0; m_cnt <= 0;
    end else begin
      me_v <= 1'b0; me_mr <= 1'b0; me_ctrl <= '0; me_src <= '0; me_dst <= '0;
      me_rsrc <= '0; me_rdst <= '0; me_imm <= '0;
      if (ex_flush) begin
        m_wait <= 1'b0; mh_src <= '0; mh_dst <= '0; mh_us <= 1'b0; mh_ud <= 1'b0;
        mh_mr <= 1'b0; mh_ctrl <= '0;
      end else if (!m_wait && !in_valid) begin
        m_wait <= 1'b0;
      end else if (m_hz()) begin
        m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      end else if (!m_wait && id_has_imm) begin
        m_wait <= 1'b1; mh_src <= id_src; mh_dst <= id_dst; mh_us <= id_uses_src;
        mh_ud <= id_uses_dst; mh_mr <= id_mem_read; mh_ctrl <= id_ctrl;
      end else if (!m_wait || in_valid) begin
        me_v    <= 1'b1;
        me_ctrl <= m_wait ? mh_ctrl : id_ctrl;
        me_mr   <= m_wait ? mh_mr : id_mem_read;
        me_src  <= m_src();
        me_dst  <= m_dst();
        me_rsrc <= rf_mem[m_src()];
        me_rdst <= rf_mem[m_dst()];
        me_imm  <= m_wait ? fetch_word : '0;
        m_wait  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("rf_src", 32'(rf_src), 32'(m_src()));
      chk("rf_dst", 32'(rf_dst), 32'(m_dst()));
      chk("stall_fetch", 32'(stall_fetch), 32'(m_stall()));
      chk("ex_valid", 32'(ex_valid), 32'(me_v));
      chk("ex_ctrl", 32'(ex_ctrl), 32'(me_ctrl));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(me_mr));
      chk("ex_src", 32'(ex_src), 32'(me_src));
      chk("ex_dst", 32'(ex_dst), 32'(me_dst));
      chk("ex_rsrc", 32'(ex_rsrc), 32'(me_rsrc));
      chk("ex_rdst", 32'(ex_rdst), 32'(me_rdst));
      chk("ex_imm", 32'(ex_imm), 32'(me_imm));
      chk("stall_count", 32'(stall_count), 32'(m_cnt));
    end
  end

  task automatic set_in(input logic v, input logic [N-1:0] s, input logic [N-1:0] d,
                        input logic us, input logic ud, input logic hi, input logic mr,
                        input logic [CW-1:0] c, input logic [W-1:0] fw, input logic fl);
    in_valid = v; id_src = s; id_dst = d; id_uses_src = us; id_uses_dst = ud;
    id_has_imm = hi; id_mem_read = mr; id_ctrl = c; fetch_word = fw; ex_flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**N; i++) rf_mem[i] = 16'hA000 + 16'(i);
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 0);
    step(); step();
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_stall_count", 32'(stall_count), 32'h0);
    chk("rst_stall_fetch", 32'(stall_fetch), 32'h0);
    chk("rst_ex_imm", 32'(ex_imm), 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Load r2 followed by a reader of r2: one bubble, then issue.
    set_in(1, 1, 2, 1, 0, 0, 1, 8'h11, 16'h0, 0); step();
    chk("lu_load_valid", 32'(ex_valid), 32'h1);
    chk("lu_load_mr", 32'(ex_mem_read), 32'h1);
    set_in(1, 2, 4, 1, 0, 0, 0, 8'h22, 16'h0, 0); #2;
    chk("lu_stall_on", 32'(stall_fetch), 32'h1);
    step();
    chk("lu_bubble", 32'(ex_valid), 32'h0);
    chk("lu_count1", 32'(stall_count), 32'h1);
    chk("lu_model_cnt", 32'(m_cnt), 32'h1);
    #2 chk("lu_stall_off", 32'(stall_fetch), 32'h0);
    step();
    chk("lu_issue", 32'(ex_valid), 32'h1);
    chk("lu_rsrc", 32'(ex_rsrc), 32'hA002);
    chk("lu_ctrl", 32'(ex_ctrl), 32'h22);

    // Same load, consumer reads only dst r5: no stall.
    set_in(1, 0, 2, 0, 0, 0, 1, 8'h11, 16'h0, 0); step();
    set_in(1, 2, 5, 0, 1, 0, 0, 8'h66, 16'h0, 0); #2;
    chk("nd_no_stall", 32'(stall_fetch), 32'h0);
    step();
    chk("nd_issue", 32'(ex_valid), 32'h1);
    chk("nd_rdst", 32'(ex_rdst), 32'hA005);
    chk("nd_count", 32'(stall_count), 32'h1);

    // Hazard through the dst read port.
    set_in(1, 0, 3, 0, 0, 0, 1, 8'h11, 16'h0, 0); step();
    set_in(1, 6, 3, 0, 1, 0, 0, 8'h77, 16'h0, 0); #2;
    chk("dh_stall", 32'(stall_fetch), 32'h1);
    step();
    chk("dh_count2", 32'(stall_count), 32'h2);
    step();
    chk("dh_ctrl", 32'(ex_ctrl), 32'h77);

    // Two-word immediate instruction.
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0, 0); step();
    set_in(1, 1, 3, 1, 1, 1, 0, 8'h33, 16'h0, 0); step();
    chk("im_bubble", 32'(ex_valid), 32'h0);
    set_in(1, 7, 7, 0, 0, 0, 0, 8'h00, 16'hBEEF, 0); #2;
    chk("im_rf_dst", 32'(rf_dst), 32'h3);
    chk("im_rf_src", 32'(rf_src), 32'h1);
    step();
    chk("im_valid", 32'(ex_valid), 32'h1);
    chk("im_imm", 32'(ex_imm), 32'hBEEF);
    chk("im_rdst", 32'(ex_rdst), 32'hA003);

    // Immediate word arrives late.
    set_in(1, 4, 2, 1, 0, 1, 0, 8'h3C, 16'h0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0, 0); step();
    chk("gap_bubble", 32'(ex_valid), 32'h0);
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h1234, 0); step();
    chk("gap_imm", 32'(ex_imm), 32'h1234);
    chk("gap_src", 32'(ex_src), 32'h4);

    // Flush while waiting for an immediate.
    set_in(1, 1, 2, 1, 1, 1, 0, 8'h44, 16'h0, 0); step();
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h7777, 1); step();
    chk("fl_bubble", 32'(ex_valid), 32'h0);
    set_in(1, 4, 6, 1, 0, 0, 0, 8'h55, 16'h9999, 0); step();
    chk("fl_new_ctrl", 32'(ex_ctrl), 32'h55);
    chk("fl_new_imm", 32'(ex_imm), 32'h0);
    chk("fl_new_dst", 32'(ex_dst), 32'h6);

    // Reset while waiting for an immediate.
    set_in(1, 2, 5, 1, 1, 1, 0, 8'h5A, 16'h0, 0); step();
    #2 rst = 1'b1;
    #1;
    chk("rr_valid", 32'(ex_valid), 32'h0);
    chk("rr_count", 32'(stall_count), 32'h0);
    chk("rr_stall", 32'(stall_fetch), 32'h0);
    step();
    rst = 1'b0;
    set_in(1, 5, 1, 1, 0, 0, 0, 8'h66, 16'hFFFF, 0); #2;
    chk("rr_rf_src", 32'(rf_src), 32'h5);
    step();
    chk("rr_issue_imm", 32'(ex_imm), 32'h0);
    chk("rr_issue_valid", 32'(ex_valid), 32'h1);

    // Back-to-back dependent loads: one hazard every two cycles until the counter saturates.
    set_in(1, 1, 1, 1, 0, 0, 1, 8'h99, 16'h0, 0);
    for (int i = 0; i < 140000 && m_cnt < 65535; i++) step();
    repeat (6) step();
    chk("sat_count", 32'(stall_count), 32'hFFFF);
    chk("sat_model", 32'(m_cnt), 32'd65535);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
